// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: round-robin read-port arbiter with burst locking in front of a banked simpleDualPortRam.
// Latency: grant and RAM address in the same cycle; rsp_valid/rsp_data one cycle after the grant.
// Backpressure: req_ready grants one requester per cycle (owner only while locked); writes are never stalled.
//
// Ports: req_valid/req_addr/req_elm/req_lock per requester in, req_ready one-hot grant out;
//   rsp_valid one-hot and shared rsp_data out; wr_* write request in; ram_* drive the RAM and ram_q returns q[0].
// Option: define RAM_ARB_BYPASS_EN to return same-cycle write data when a read hits the address being written.
// Element index width uses $clog2(WORDS), the same value globalDefinitions::log2 yields for power-of-two WORDS.
module ram_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_SIZE  = 16,
  parameter int WORDS      = 4,
  parameter int MAX_BURST  = 8,
  localparam int EW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][EW-1:0]           req_elm,
  input  logic [NUM_REQ-1:0]                   req_lock,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [WORD_SIZE-1:0]                 rsp_data,
  input  logic                                 wr_valid,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [EW-1:0]                        wr_elm,
  input  logic [WORD_SIZE-1:0]                 wr_data,
  output logic [ADDR_WIDTH-1:0]                ram_raddr,
  output logic [EW-1:0]                        ram_raddrElm,
  output logic [ADDR_WIDTH-1:0]                ram_waddr,
  output logic [EW-1:0]                        ram_waddrElm,
  output logic [WORD_SIZE-1:0]                 ram_wdata,
  output logic                                 ram_we,
  input  logic [WORD_SIZE-1:0]                 ram_q
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           rr_ptr, rr_nxt;
  logic [PW-1:0]           owner, owner_nxt;
  logic [CW-1:0]           burst_cnt, cnt_nxt;
  logic                    win_found;
  logic [PW-1:0]           win_idx;
  logic                    grant_any;
  logic [PW-1:0]           grant_idx;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [EW-1:0]           relm_q;
  logic [WORD_SIZE-1:0]    rsp_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  // Next-state logic. A locked owner that is idle for a cycle simply holds.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    cnt_nxt   = burst_cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          if (req_lock[win_idx]) begin
            state_nxt = LOCKED;
            owner_nxt = win_idx;
            cnt_nxt   = CW'(1);
          end else begin
            rr_nxt = ptr_inc(win_idx);
          end
        end
      end
      LOCKED: begin
        if (req_valid[owner]) begin
          if (req_lock[owner] && (burst_cnt < CW'(MAX_BURST - 1))) begin
            cnt_nxt = burst_cnt + 1'b1;
          end else begin
            // Final beat: release and let the next requester after the owner go first.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            rr_nxt    = ptr_inc(owner);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: one-hot grant, only ever set for a valid requester.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    if (state == IDLE) begin
      grant_idx = win_idx;
      if (win_found) req_ready[win_idx] = 1'b1;
    end else begin
      grant_idx = owner;
      if (req_valid[owner]) req_ready[owner] = 1'b1;
    end
  end

  assign grant_any = |req_ready;

  // The RAM samples the winner's address directly; without a grant it sees the last granted address.
  assign ram_raddr    = grant_any ? req_addr[grant_idx] : raddr_q;
  assign ram_raddrElm = grant_any ? req_elm[grant_idx]  : relm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q   <= '0;
      relm_q    <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= req_ready;
      if (grant_any) begin
        raddr_q <= ram_raddr;
        relm_q  <= ram_raddrElm;
      end
    end
  end

`ifdef RAM_ARB_BYPASS_EN
  // The RAM is read-first, so a read colliding with a same-cycle write would return stale data;
  // capture the write data at grant time and substitute it next cycle.
  logic                 hit_q;
  logic [WORD_SIZE-1:0] byp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      byp_q <= '0;
    end else begin
      hit_q <= grant_any && wr_valid && (wr_addr == ram_raddr) && (wr_elm == ram_raddrElm);
      if (grant_any) byp_q <= wr_data;
    end
  end

  assign rsp_word = hit_q ? byp_q : ram_q;
`else
  assign rsp_word = ram_q;
`endif

  assign rsp_data = (|rsp_valid) ? rsp_word : '0;

  // Write port is a straight pass-through; it never touches arbitration.
  assign ram_we       = wr_valid;
  assign ram_waddr    = wr_addr;
  assign ram_waddrElm = wr_elm;
  assign ram_wdata    = wr_data;

endmodule

// File: tb/tb_ram_read_arbiter.sv
// tb_ram_read_arbiter: randomized and directed stimulus against a beat-counting arbitration model.
// Latency: checks grant/address in the grant cycle and the response one cycle later.
// Backpressure: a requester is stalled whenever the model says another one owns the port.
module tb_ram_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int WS = 16;
  localparam int EW = 2;
  localparam int MB = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][EW-1:0] req_elm;
  logic [N-1:0]         req_lock;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         rsp_valid;
  logic [WS-1:0]        rsp_data;
  logic                 wr_valid;
  logic [AW-1:0]        wr_addr;
  logic [EW-1:0]        wr_elm;
  logic [WS-1:0]        wr_data;
  logic [AW-1:0]        ram_raddr;
  logic [EW-1:0]        ram_raddrElm;
  logic [AW-1:0]        ram_waddr;
  logic [EW-1:0]        ram_waddrElm;
  logic [WS-1:0]        ram_wdata;
  logic                 ram_we;
  logic [WS-1:0]        ram_q;

  ram_read_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .WORD_SIZE(WS), .WORDS(4), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_elm(req_elm), .req_lock(req_lock),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_elm(wr_elm), .wr_data(wr_data),
    .ram_raddr(ram_raddr), .ram_raddrElm(ram_raddrElm),
    .ram_waddr(ram_waddr), .ram_waddrElm(ram_waddrElm),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Read-first RAM with one-cycle read latency, cleared by reset.
  logic [WS-1:0] ram [256][4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 256; a++)
        for (int e = 0; e < 4; e++) ram[a][e] <= '0;
      ram_q <= '0;
    end else begin
      ram_q <= ram[ram_raddr][ram_raddrElm];
      if (ram_we) ram[ram_waddr][ram_waddrElm] <= ram_wdata;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: owner (-1 = none), beats taken by the owner, next round-robin start.
  int            m_owner;
  int            m_beats;
  int            m_rr;
  logic [AW-1:0] m_addr;
  logic [EW-1:0] m_elm;
  logic [WS-1:0] ref_mem [256][4];

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_rr    = 0;
    m_addr  = '0;
    m_elm   = '0;
    for (int a = 0; a < 256; a++)
      for (int e = 0; e < 4; e++) ref_mem[a][e] = '0;
  endtask

  function automatic int pick();
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic idle_inputs();
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_elm   = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_elm    = '0;
    wr_data   = '0;
  endtask

  // One cycle: inputs already driven at posedge+1; returns at the next posedge+1.
  task automatic step();
    int            g;
    logic [N-1:0]  exp_rdy;
    logic [AW-1:0] ea;
    logic [EW-1:0] ee;
    logic [WS-1:0] ed;
    #1;
    g       = pick();
    exp_rdy = '0;
    ea      = m_addr;
    ee      = m_elm;
    ed      = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      ea = req_addr[g];
      ee = req_elm[g];
      ed = ref_mem[ea][ee];
`ifdef RAM_ARB_BYPASS_EN
      if (wr_valid && wr_addr == ea && wr_elm == ee) ed = wr_data;
`endif
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("ram_raddr", 32'({ram_raddr, ram_raddrElm}), 32'({ea, ee}));
    chk("wr_pass", 32'({ram_we, ram_waddr, ram_waddrElm, ram_wdata}),
        32'({wr_valid, wr_addr, wr_elm, wr_data}));
    // Advance the model.
    if (g >= 0) begin
      if (m_owner < 0) begin
        if (req_lock[g]) begin
          m_owner = g;
          m_beats = 1;
        end else begin
          m_rr = (g + 1) % N;
        end
      end else begin
        m_beats++;
        if (!req_lock[g] || m_beats == MB) begin
          m_rr    = (m_owner + 1) % N;
          m_owner = -1;
          m_beats = 0;
        end
      end
    end
    m_addr = ea;
    m_elm  = ee;
    if (wr_valid) ref_mem[wr_addr][wr_elm] = wr_data;
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rdy));
    chk("rsp_data", 32'(rsp_data), 32'(ed));
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      req_addr[i] = AW'($urandom_range(0, 3));
      req_elm[i]  = EW'($urandom_range(0, 3));
      req_valid[i] = ($urandom_range(0, 99) < 60);
      req_lock[i]  = ($urandom_range(0, 99) < 30);
    end
    wr_valid = ($urandom_range(0, 99) < 50);
    wr_addr  = AW'($urandom_range(0, 3));
    wr_elm   = EW'($urandom_range(0, 3));
    wr_data  = WS'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_raddr", 32'({ram_raddr, ram_raddrElm}), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All requesters valid, no locks: strict rotation 0,1,2,3,0,1,2,3.
    for (int c = 0; c < 8; c++) begin
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
        req_addr[i] = AW'(16 + i);
        req_elm[i]  = EW'(i);
      end
      step();
    end

    // Preload row 5 elm 2 through the write port, then requester 1 reads it back.
    idle_inputs();
    wr_valid = 1'b1; wr_addr = 8'd5; wr_elm = 2'd2; wr_data = 16'hABCD;
    step();
    idle_inputs();
    req_valid[1] = 1'b1; req_addr[1] = 8'd5; req_elm[1] = 2'd2;
    step();
    chk("preload_read", 32'(rsp_data), 32'h0000ABCD);

    // Requester 2 bursts with lock while requester 0 waits; the final cycle drops the lock.
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      req_valid   = 4'b0101;
      req_lock[2] = (c < 11);
      req_addr[0] = AW'(40 + c);
      req_addr[2] = AW'(60 + c);
      step();
    end

    // Read and write to the same location in the same cycle over old data 0.
    idle_inputs();
    wr_valid = 1'b1; wr_addr = 8'd7; wr_elm = 2'd1; wr_data = 16'h1234;
    req_valid[0] = 1'b1; req_addr[0] = 8'd7; req_elm[0] = 2'd1;
    step();
`ifdef RAM_ARB_BYPASS_EN
    chk("same_cycle_rw", 32'(rsp_data), 32'h00001234);
`else
    chk("same_cycle_rw", 32'(rsp_data), 32'h00000000);
`endif

    // Idle cycles: address holds, nothing returned.
    idle_inputs();
    repeat (3) step();

    // Randomized traffic with heavy address reuse.
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      step();
    end

    // Flush any lock, build a locked burst with a read in flight, then reset.
    idle_inputs();
    req_valid = '1;
    repeat (2) step();
    idle_inputs();
    req_valid = 4'b0100; req_lock = 4'b0100; req_addr[2] = 8'd9;
    repeat (2) step();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("inrst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = '1;
    step();
    chk("postrst_first_rsp", 32'(rsp_valid), 32'b0001);

    // Only requester 3, then only requester 0: back-to-back across the wrap.
    idle_inputs();
    req_valid = 4'b1000; req_addr[3] = 8'd3;
    step();
    chk("wrap_rsp3", 32'(rsp_valid), 32'b1000);
    idle_inputs();
    req_valid = 4'b0001; req_addr[0] = 8'd4;
    step();
    chk("wrap_rsp0", 32'(rsp_valid), 32'b0001);

    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
